// File: rtl/btn_debounce_bank_if.sv
// Debounce bank signal bundle: sample enable and raw levels in, debounced levels and pulses out.
interface btn_debounce_bank_if #(
    parameter int unsigned CHANNELS = 4
);
    logic                tick;
    logic [CHANNELS-1:0] in;
    logic [CHANNELS-1:0] out;
    logic [CHANNELS-1:0] rise;
    logic [CHANNELS-1:0] fall;
    logic [CHANNELS-1:0] long_press;

    modport master (
        output tick, in,
        input  out, rise, fall, long_press
    );

    modport slave (
        input  tick, in,
        output out, rise, fall, long_press
    );
endinterface

// File: rtl/btn_debounce_bank.sv
// Bank of independent integrating debouncers with hysteresis and edge pulses.
// Optional long-press detection is built when BTN_LONGPRESS_EN is defined.
module btn_debounce_bank #(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned CNT_W    = 8,
    parameter int unsigned SET_TH   = 200,
    parameter int unsigned CLR_TH   = 0,
    parameter logic [15:0] LONG_CYC = 16'd1000
) (
    input  logic               clk,
    input  logic               rst,
    btn_debounce_bank_if.slave bus
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] SET_V   = CNT_W'(SET_TH);
    localparam logic [CNT_W-1:0] CLR_V   = CNT_W'(CLR_TH);

    if (!((CLR_TH < SET_TH) && (64'(SET_TH) <= ((64'd1 << CNT_W) - 64'd1)))) begin : g_bad_thresholds
        $error("btn_debounce_bank: thresholds must satisfy CLR_TH < SET_TH <= 2^CNT_W-1");
    end

    logic [CHANNELS-1:0]            r_sync1;
    logic [CHANNELS-1:0]            r_sync2;
    logic [CHANNELS-1:0][CNT_W-1:0] r_cnt;
    logic [CHANNELS-1:0]            r_out;
    logic [CHANNELS-1:0]            r_out_d;
    logic [CHANNELS-1:0]            r_rise;
    logic [CHANNELS-1:0]            r_fall;

    logic [CHANNELS-1:0][CNT_W-1:0] w_cnt_nxt;
    logic [CHANNELS-1:0]            w_out_nxt;

    // Saturating integrator; the output thresholds look at the updated count.
    always_comb begin
        w_cnt_nxt = r_cnt;
        w_out_nxt = r_out;
        for (int unsigned ch = 0; ch < CHANNELS; ch++) begin
            if (bus.tick) begin
                if (r_sync2[ch] && (r_cnt[ch] != CNT_MAX)) begin
                    w_cnt_nxt[ch] = r_cnt[ch] + 1'b1;
                end else if (!r_sync2[ch] && (r_cnt[ch] != '0)) begin
                    w_cnt_nxt[ch] = r_cnt[ch] - 1'b1;
                end
                if (w_cnt_nxt[ch] >= SET_V) begin
                    w_out_nxt[ch] = 1'b1;
                end else if (w_cnt_nxt[ch] <= CLR_V) begin
                    w_out_nxt[ch] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_cnt   <= '0;
            r_out   <= '0;
            r_out_d <= '0;
            r_rise  <= '0;
            r_fall  <= '0;
        end else begin
            r_sync1 <= bus.in;
            r_sync2 <= r_sync1;
            r_cnt   <= w_cnt_nxt;
            r_out   <= w_out_nxt;
            r_out_d <= r_out;
            r_rise  <= r_out & ~r_out_d;
            r_fall  <= ~r_out & r_out_d;
        end
    end

    assign bus.out  = r_out;
    assign bus.rise = r_rise;
    assign bus.fall = r_fall;

`ifdef BTN_LONGPRESS_EN
    if (LONG_CYC == 16'd0) begin : g_bad_long
        $error("btn_debounce_bank: LONG_CYC must be non-zero");
    end

    logic [CHANNELS-1:0][15:0] r_lcnt;
    logic [CHANNELS-1:0]       r_lp;

    // Counter saturates at LONG_CYC, so each press yields at most one pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lcnt <= '0;
            r_lp   <= '0;
        end else begin
            for (int unsigned ch = 0; ch < CHANNELS; ch++) begin
                r_lp[ch] <= 1'b0;
                if (!r_out[ch]) begin
                    r_lcnt[ch] <= '0;
                end else if (bus.tick && (r_lcnt[ch] != LONG_CYC)) begin
                    r_lcnt[ch] <= r_lcnt[ch] + 16'd1;
                    r_lp[ch]   <= (r_lcnt[ch] == (LONG_CYC - 16'd1));
                end
            end
        end
    end

    assign bus.long_press = r_lp;
`else
    assign bus.long_press = '0;
`endif
endmodule

// File: tb/tb_btn_debounce_bank.sv
// Randomised and directed scoreboard bench for btn_debounce_bank (2 channels, small thresholds).
module tb_btn_debounce_bank;
    localparam int NCH  = 2;
    localparam int MAXC = 15;
    localparam int SET  = 10;
    localparam int CLR  = 2;
    localparam int LONG = 20;

    typedef struct packed {
        logic [1:0] out;
        logic [1:0] rise;
        logic [1:0] fall;
        logic [1:0] lp;
    } resp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_err    = 0;
    resp_t q[$];

    int m_cnt[NCH];
    int m_lc[NCH];
    bit m_s1[NCH];
    bit m_s2[NCH];
    bit m_out[NCH];
    bit m_outp[NCH];

    btn_debounce_bank_if #(.CHANNELS(NCH)) bus ();

    btn_debounce_bank #(
        .CHANNELS(NCH),
        .CNT_W(4),
        .SET_TH(SET),
        .CLR_TH(CLR),
        .LONG_CYC(16'd20)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [1:0] got, input logic [1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_cnt[c] = 0; m_lc[c] = 0; m_s1[c] = 0; m_s2[c] = 0;
            m_out[c] = 0; m_outp[c] = 0;
        end
    endtask

    // Drive one cycle of stimulus and queue what the DUT should show after the next edge.
    task automatic step(input logic [1:0] vin, input logic vtick, input bit do_rst = 1'b0);
        resp_t e;
        @(negedge clk);
        if (do_rst) begin
            #1 rst = 1'b1;
            #1;
            chk("rst_out",  bus.out,        2'b00);
            chk("rst_rise", bus.rise,       2'b00);
            chk("rst_fall", bus.fall,       2'b00);
            chk("rst_lp",   bus.long_press, 2'b00);
            rst = 1'b0;
            model_reset();
        end
        bus.in   = vin;
        bus.tick = vtick;
        e = '0;
        for (int c = 0; c < NCH; c++) begin
            int nc;
            bit o;
            e.rise[c] = m_out[c] && !m_outp[c];
            e.fall[c] = !m_out[c] && m_outp[c];
            if (!m_out[c]) m_lc[c] = 0;
            else if (vtick && m_lc[c] < LONG) begin
                m_lc[c]++;
`ifdef BTN_LONGPRESS_EN
                e.lp[c] = (m_lc[c] == LONG);
`endif
            end
            nc = m_cnt[c];
            o  = m_out[c];
            if (vtick) begin
                if (m_s2[c]) nc = (m_cnt[c] + 1 > MAXC) ? MAXC : m_cnt[c] + 1;
                else         nc = (m_cnt[c] - 1 < 0)    ? 0    : m_cnt[c] - 1;
                if (nc >= SET)      o = 1'b1;
                else if (nc <= CLR) o = 1'b0;
            end
            e.out[c]  = o;
            m_outp[c] = m_out[c];
            m_out[c]  = o;
            m_cnt[c]  = nc;
            m_s2[c]   = m_s1[c];
            m_s1[c]   = vin[c];
        end
        q.push_back(e);
    endtask

    initial begin : monitor
        resp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("out",        bus.out,        e.out);
                chk("rise",       bus.rise,       e.rise);
                chk("fall",       bus.fall,       e.fall);
                chk("long_press", bus.long_press, e.lp);
            end
        end
    end

    initial begin : driver
        logic [1:0] lvl;
        logic [1:0] vin;
        bus.in   = '0;
        bus.tick = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);

        // Clean press on channel 0, held long enough to saturate and reach a long press.
        step(2'b01, 1'b1, 1'b1);
        for (int i = 1; i < 12; i++) step(2'b01, 1'b1);
        chk("press_before_edge", bus.out, 2'b00);
        step(2'b01, 1'b1);
        chk("press_at_edge", bus.out, 2'b01);
        for (int i = 0; i < 40; i++) step(2'b01, 1'b1);

        // Release from saturation: output drops on the 13th tick after the synchroniser.
        for (int i = 0; i < 15; i++) step(2'b00, 1'b1);
        chk("release_before_edge", bus.out, 2'b01);
        step(2'b00, 1'b1);
        chk("release_at_edge", bus.out, 2'b00);
        for (int i = 0; i < 5; i++) step(2'b00, 1'b1);

        // Short bounce from saturation must not release.
        for (int i = 0; i < 20; i++) step(2'b01, 1'b1);
        for (int i = 0; i < 5; i++)  step(2'b00, 1'b1);
        for (int i = 0; i < 10; i++) step(2'b01, 1'b1);
        chk("bounce_hold", bus.out, 2'b01);

        // Sparse ticks: one sample enable every fourth clock.
        for (int i = 0; i < 80; i++) step(2'b10, (i % 4) == 0);
        chk("tick_gated", bus.out, 2'b10);

        // Asynchronous reset mid-press.
        for (int i = 0; i < 20; i++) step(2'b11, 1'b1);
        chk("pre_reset", bus.out, 2'b11);
        step(2'b00, 1'b1, 1'b1);
        for (int i = 0; i < 6; i++) step(2'b00, 1'b1);

        // Random levels with bounces, sparse ticks and occasional resets.
        lvl = '0;
        for (int i = 0; i < 700; i++) begin
            for (int c = 0; c < NCH; c++)
                if ($urandom_range(0, 29) == 0) lvl[c] = ~lvl[c];
            vin = lvl;
            for (int c = 0; c < NCH; c++)
                if ($urandom_range(0, 15) == 0) vin[c] = ~vin[c];
            step(vin, $urandom_range(0, 3) != 0, $urandom_range(0, 249) == 0);
        end
        for (int i = 0; i < 4; i++) step(2'b00, 1'b1);

        @(negedge clk);
        repeat (2) @(posedge clk);
        #2;
        n_checks++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
